// File: rtl/fft_bin_power.sv
// fft_bin_power: converts a stream of complex FFT bins into per-bin power words.
//
// Sits between the FFT core output stream and tone_detection_fsm. Each accepted
// bin {im, re} yields one unsigned power word re^2 + im^2, tagged with its bin
// index and a frame-aligned last flag. Frame length is checked against FFT_LEN.
//
// Ports:
//   clk_in     system clock
//   rst_in     asynchronous, active-low reset
//   s_data     input bin, [2*DATA_W-1:DATA_W] = im, [DATA_W-1:0] = re (signed)
//   s_valid    s_data valid
//   s_last     last bin of the input frame
//   s_ready    block can accept a bin this cycle
//   m_data     unsigned power re^2 + im^2 (saturated)
//   m_bin      bin index of m_data
//   m_valid    m_data/m_bin/m_last valid
//   m_last     last output bin of the frame
//   m_ready    downstream accepts
//   frame_err  one-cycle pulse after a bin that ends a malformed frame
//
// Build option: define FFT_BIN_POWER_HALF_SPECTRUM_EN to forward only bins
// 0..FFT_LEN/2-1 (the upper half of a real-input spectrum is a mirror image).
module fft_bin_power #(
    parameter int FFT_LEN = 2048,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 11
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [2*DATA_W-1:0] s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic [2*DATA_W-1:0] m_data,
    output logic [IDX_W-1:0]    m_bin,
    output logic                m_valid,
    output logic                m_last,
    input  logic                m_ready,
    output logic                frame_err
);

    localparam int PW = 2 * DATA_W;
    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(FFT_LEN - 1);
    localparam logic [IDX_W-1:0] HALF_LAST = IDX_W'(FFT_LEN / 2 - 1);

    generate
        if (FFT_LEN < 4 || (1 << IDX_W) != FFT_LEN) begin : g_bad_cfg
            $error("fft_bin_power: FFT_LEN must be a power of two >= 4 and equal 2**IDX_W");
        end
    endgenerate

    logic                en_q;
    logic [IDX_W-1:0]    bin_q, bin_d;
    logic                err_q, err_d;
    logic                s1_valid_q, s1_valid_d;
    logic [PW-1:0]       s1_re2_q, s1_re2_d;
    logic [PW-1:0]       s1_im2_q, s1_im2_d;
    logic [IDX_W-1:0]    s1_bin_q, s1_bin_d;
    logic                s1_last_q, s1_last_d;
    logic                m_valid_q, m_valid_d;
    logic [PW-1:0]       m_data_q, m_data_d;
    logic [IDX_W-1:0]    m_bin_q, m_bin_d;
    logic                m_last_q, m_last_d;

    logic signed [PW-1:0] re_x, im_x;
    logic [PW-1:0]        re2, im2;
    logic [PW:0]          sum;
    logic                 s2_load, s1_adv, in_xfer;
    logic                 end_bin, frame_end, keep, tag_last;

    // Sign-extend before squaring so the product is exact in PW bits.
    assign re_x = {{DATA_W{s_data[DATA_W-1]}}, s_data[DATA_W-1:0]};
    assign im_x = {{DATA_W{s_data[PW-1]}}, s_data[PW-1:DATA_W]};
    assign re2  = $unsigned(re_x * re_x);
    assign im2  = $unsigned(im_x * im_x);
    assign sum  = {1'b0, s1_re2_q} + {1'b0, s1_im2_q};

    // m_ready -> s_ready is the only combinational path through the block.
    assign s2_load = !m_valid_q || m_ready;
    assign s1_adv  = s1_valid_q && s2_load;
    assign s_ready = en_q && (!s1_valid_q || s2_load);
    assign in_xfer = s_valid && s_ready;

    assign end_bin   = bin_q == LAST_BIN;
    assign frame_end = s_last || end_bin;

`ifdef FFT_BIN_POWER_HALF_SPECTRUM_EN
    assign keep     = !bin_q[IDX_W-1];
    assign tag_last = s_last || bin_q == HALF_LAST;
`else
    assign keep     = 1'b1;
    assign tag_last = frame_end;
`endif

    always_comb begin
        bin_d      = in_xfer ? (frame_end ? '0 : bin_q + 1'b1) : bin_q;
        err_d      = in_xfer && (s_last != end_bin);
        s1_valid_d = s_ready ? (in_xfer && keep) : s1_valid_q;
        s1_re2_d   = in_xfer ? re2 : s1_re2_q;
        s1_im2_d   = in_xfer ? im2 : s1_im2_q;
        s1_bin_d   = in_xfer ? bin_q : s1_bin_q;
        s1_last_d  = in_xfer ? tag_last : s1_last_q;
        m_valid_d  = s2_load ? s1_valid_q : m_valid_q;
        // Legal inputs keep the sum below 2^(PW-1); only the double most-negative
        // corner reaches it, and it is clamped to full scale.
        m_data_d   = s1_adv ? ((|sum[PW:PW-1]) ? '1 : sum[PW-1:0]) : m_data_q;
        m_bin_d    = s1_adv ? s1_bin_q : m_bin_q;
        m_last_d   = s1_adv ? s1_last_q : m_last_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            en_q       <= 1'b0;
            bin_q      <= '0;
            err_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_re2_q   <= '0;
            s1_im2_q   <= '0;
            s1_bin_q   <= '0;
            s1_last_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_bin_q    <= '0;
            m_last_q   <= 1'b0;
        end else begin
            en_q       <= 1'b1;
            bin_q      <= bin_d;
            err_q      <= err_d;
            s1_valid_q <= s1_valid_d;
            s1_re2_q   <= s1_re2_d;
            s1_im2_q   <= s1_im2_d;
            s1_bin_q   <= s1_bin_d;
            s1_last_q  <= s1_last_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_bin_q    <= m_bin_d;
            m_last_q   <= m_last_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_bin     = m_bin_q;
    assign m_last    = m_last_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_fft_bin_power.sv
// tb_fft_bin_power: randomized and directed checks of fft_bin_power against a queue model.
module tb_fft_bin_power;

    localparam int N  = 2048;
    localparam int DW = 16;
    localparam int IW = 11;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b0;
    logic [2*DW-1:0] s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_last = 1'b0;
    logic            s_ready;
    logic [2*DW-1:0] m_data;
    logic [IW-1:0]   m_bin;
    logic            m_valid;
    logic            m_last;
    logic            m_ready = 1'b0;
    logic            frame_err;

    fft_bin_power #(.FFT_LEN(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_bin(m_bin), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .frame_err(frame_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [63:0] pw;
        int          bin;
        bit          last;
        int          t;
    } exp_t;

    exp_t q[$];
    int   pos = 0;
    bit   err_exp = 0;
    int   cyc = 0;
    bit   lat_chk = 0;
    bit   took = 0;
    int   n_out = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: power from integer arithmetic, index and last flag from frame position.
    task automatic accept();
        int          re, im, p_bin;
        logic [63:0] p;
        bit          full_end, keep, lst;
        re = int'($signed(s_data[DW-1:0]));
        im = int'($signed(s_data[2*DW-1:DW]));
        p = 64'(longint'(re) * re + longint'(im) * im);
        if (re == -32768 && im == -32768) p = 64'hFFFF_FFFF;
        p_bin = pos;
        full_end = (pos == N - 1);
        err_exp = (s_last != full_end);
`ifdef FFT_BIN_POWER_HALF_SPECTRUM_EN
        keep = pos < N / 2;
        lst = s_last || pos == N / 2 - 1;
`else
        keep = 1;
        lst = s_last || full_end;
`endif
        if (keep) q.push_back('{pw: p, bin: p_bin, last: lst, t: cyc});
        pos = (s_last || full_end) ? 0 : pos + 1;
    endtask

    task automatic clear_model();
        q.delete();
        pos = 0;
        err_exp = 0;
    endtask

    // Called at a negedge with inputs already driven; observes, updates the model, advances one cycle.
    task automatic step();
        #1;
        chk("frame_err", frame_err, err_exp);
        err_exp = 0;
        if (m_valid) begin
            if (q.size() == 0) chk("spurious_valid", 1, 0);
            else begin
                chk("m_data", m_data, q[0].pw);
                chk("m_bin", m_bin, q[0].bin);
                chk("m_last", m_last, q[0].last);
                if (lat_chk && m_ready) chk("latency", cyc - q[0].t, 2);
                if (m_ready) begin
                    void'(q.pop_front());
                    n_out++;
                end
            end
        end
        took = s_valid && s_ready;
        if (took) accept();
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic send(input logic [DW-1:0] im, input logic [DW-1:0] re, input bit last);
        s_valid = 1;
        s_data = {im, re};
        s_last = last;
        took = 0;
        for (int g = 0; g < 200 && !took; g++) step();
        if (!took) chk("accept_timeout", 0, 1);
        s_valid = 0;
        s_last = 0;
    endtask

    task automatic drain();
        s_valid = 0;
        m_ready = 1;
        for (int g = 0; g < 50 && (q.size() != 0 || m_valid); g++) step();
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        rst_in = 0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_bin", m_bin, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_s_ready", s_ready, 0);
        clear_model();
        repeat (3) @(negedge clk_in);
        rst_in = 1;
        #1;
        chk("rel_s_ready_low", s_ready, 0);
        @(negedge clk_in);
        chk("rel_s_ready_up", s_ready, 1);
        chk("rel_m_valid", m_valid, 0);
    endtask

    function automatic logic [DW-1:0] rnd();
        case ($urandom % 8)
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    int acc;

    initial begin
        @(negedge clk_in);
        do_reset();

        // Full-length frame, m_ready held high: latency and index checks.
        m_ready = 1;
        lat_chk = 1;
        n_out = 0;
        for (int n = 0; n < N; n++) send(16'(n), 16'd3, n == N - 1);
        drain();
        lat_chk = 0;
`ifdef FFT_BIN_POWER_HALF_SPECTRUM_EN
        chk("half_out_count", n_out, N / 2);
`else
        chk("full_out_count", n_out, N);
`endif

        // Backpressure: pipeline full, downstream stalls for 10 cycles.
        do_reset();
        m_ready = 1;
        for (int n = 0; n < 20; n++) send(rnd(), rnd(), 0);
        m_ready = 0;
        s_valid = 1;
        s_data = {rnd(), rnd()};
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (took) acc++;
        end
        chk("bp_accepts", acc, 0);
        chk("bp_held", q.size(), 2);
        chk("bp_s_ready", s_ready, 0);
        chk("bp_m_valid", m_valid, 1);
        m_ready = 1;
        for (int n = 0; n < 8; n++) begin
            send(rnd(), rnd(), 0);
            chk("bp_gapfree", m_valid, 1);
        end
        drain();

        // Arithmetic corners.
        do_reset();
        send(16'h8000, 16'h8000, 0);
        send(16'h0000, 16'h7FFF, 0);
        send(16'hFFFF, 16'hFFFF, 0);
        drain();

        // Short frame ending at bin 100, then a fresh frame.
        do_reset();
        for (int n = 0; n <= 100; n++) send(rnd(), rnd(), n == 100);
        for (int n = 0; n < 5; n++) send(rnd(), rnd(), 0);
        drain();

        // Long frame: 2049 bins, no s_last.
        do_reset();
        for (int n = 0; n < N + 1; n++) send(16'(n), 16'(n), 0);
        drain();

        // Random traffic with an asynchronous reset in the middle.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 rst_in = 0;
                #1;
                chk("midrst_m_valid", m_valid, 0);
                chk("midrst_m_data", m_data, 0);
                chk("midrst_m_last", m_last, 0);
                chk("midrst_s_ready", s_ready, 0);
                clear_model();
                @(negedge clk_in);
                rst_in = 1;
            end
            s_valid = ($urandom % 10) < 7;
            m_ready = ($urandom % 10) < 7;
            s_data = {rnd(), rnd()};
            s_last = ($urandom % 100) == 0;
            step();
        end
        s_last = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_bin_power.md
Name: fft_bin_power

Overview:
- Sits between the FFT core's output stream and tone_detection_fsm.
- Takes complex FFT bins as packed {im, re} signed words, with valid/ready/last handshaking.
- Produces one unsigned power word per bin (re^2 + im^2) plus the bin index and a frame-aligned last flag.
- Checks frame length against FFT_LEN and flags malformed frames.

Parameters:
- FFT_LEN, 2048, bins per frame; must be a power of two, at least 4.
- DATA_W, 16, width of each signed real/imag component.
- IDX_W, 11, bin index width; equals log2(FFT_LEN).

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  asynchronous, active-low reset
- s_data  input  2*DATA_W  FFT bin; [2*DATA_W-1:DATA_W] = im, [DATA_W-1:0] = re, both two's complement
- s_valid  input  1  s_data valid
- s_last  input  1  last bin of FFT frame
- s_ready  output  1  block can accept a bin this cycle
- m_data  output  2*DATA_W  unsigned power re^2 + im^2
- m_bin  output  IDX_W  bin index of m_data
- m_valid  output  1  m_data/m_bin/m_last valid
- m_last  output  1  last output bin of frame
- m_ready  input  1  downstream (tone_detection_fsm) accepts
- frame_err  output  1  one-cycle pulse on a frame length error

Behaviour:
- Reset (rst_in low, asynchronous): m_valid=0, m_last=0, m_data=0, m_bin=0, frame_err=0, s_ready=0, bin counter=0, both pipeline stages empty.
- s_ready rises in the first cycle after rst_in deasserts.
- Reset mid-frame discards all in-flight bins; the next accepted bin is treated as bin 0.
- Input transfer occurs when s_valid && s_ready. Output transfer occurs when m_valid && m_ready.
- Pipeline has two registered stages with bubble collapsing:
  - S1 registers re*re and im*im, each 2*DATA_W bits unsigned, plus bin index and last.
  - S2 registers the sum as m_data, with m_bin and m_last.
  - Stage k loads when it is empty or its contents move onward that cycle.
  - s_ready = !S1_valid || S1_advances.
  - The only combinational path is m_ready -> s_ready.
- Latency: 2 cycles from input transfer to m_valid when m_ready is held high. Throughput is 1 bin/cycle.
- Backpressure: with m_ready low, at most 2 bins are held. A third is refused (s_ready=0). No data is lost or duplicated. Outputs stay stable while m_valid && !m_ready.
- Arithmetic:
  - Sum is computed in 2*DATA_W+1 bits, then saturated to 2*DATA_W bits.
  - Only re = im = -2^(DATA_W-1) exceeds range; it saturates to all-ones (0xFFFFFFFF at default).
- Bin counter:
  - Increments on every input transfer and is tagged onto that bin.
  - Returns to 0 after the bin carrying s_last, or after bin FFT_LEN-1, whichever comes first.
- Frame errors: frame_err pulses the cycle after the offending input transfer in each case below.
  - s_last on bin != FFT_LEN-1 (short frame): bin is forwarded with m_last=1; counter resets.
  - Bin FFT_LEN-1 without s_last (long frame): bin is forwarded with m_last=1; counter wraps to 0.
- m_last is driven from the counter rule above, not copied raw from s_last.
- Simultaneous input and output transfer in one cycle is normal operation; occupancy is unchanged.

Optional Feature:
- Macro: FFT_BIN_POWER_HALF_SPECTRUM_EN.
- Defined:
  - Bins with index >= FFT_LEN/2 are accepted (s_ready per normal rule) but never enter S1; no output is produced for them.
  - m_last is asserted on bin FFT_LEN/2-1.
  - Frame-error checks still run on the full FFT_LEN count.
  - A short frame ending before FFT_LEN/2 sets m_last on its last bin.
- Undefined: all FFT_LEN bins are forwarded, as described in Behaviour.

Test Plan:
- Reset/idle: hold rst_in=0 for 3 cycles, then release -> all outputs 0; s_ready=1 one cycle after release; no m_valid.
- Streaming: 2048 bins, bin n = {im=n, re=3}, s_last on n=2047, m_ready=1 -> m_data(n) = 9+n^2, m_bin=n, m_valid 2 cycles after each input, m_last only at bin 2047, frame_err never.
- Backpressure: m_ready=0 for 10 cycles mid-frame with s_valid=1 -> exactly 2 bins buffered, s_ready=0 thereafter, outputs stable; on release the sequence is gap-free and in order.
- Boundary arithmetic: re=im=-32768 -> m_data=0xFFFFFFFF. re=32767, im=0 -> 0x3FFF0001. re=-1, im=-1 -> 2.
- Frame errors: s_last at bin 100 -> m_last on m_bin=100, frame_err pulse, next bin has m_bin=0. A 2049-bin frame without s_last -> m_last at bin 2047, frame_err, bin 2048 reported as m_bin=0.
- Half spectrum (macro defined): 2048-bin frame -> 1024 outputs, m_last at m_bin=1023, no output for bins 1024-2047, frame_err=0. Also assert rst_in at bin 500 -> outputs clear immediately; the next frame starts at m_bin=0.
